// File: rtl/misr_periph.sv
// Memory-mapped MISR peripheral: register file, signature compression of DATA writes,
// and a word-count FSM that raises done/irq after LEN words.
module misr_periph #(
  parameter int unsigned          NBIT_DATA              = 32,
  parameter int unsigned          NBIT_ADDR              = 32,
  parameter longint unsigned      MISR_PERIPH_START_ADDR = 2**25,
  parameter logic [NBIT_DATA-1:0] POLY_RESET             = 32'h04C1_1DB7
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 re_misr_i,
  input  logic                 we_misr_i,
  input  logic [NBIT_ADDR-1:0] addr_misr_i,
  input  logic [NBIT_DATA-1:0] data_misr_i,
  output logic [NBIT_DATA-1:0] rdata_o,
  output logic                 rvalid_o,
  output logic                 err_o,
  output logic                 irq_o
);

  localparam logic [NBIT_ADDR-1:0] BASE = NBIT_ADDR'(MISR_PERIPH_START_ADDR);

  typedef enum logic [2:0] {
    R_CTRL = 3'd0, R_STATUS = 3'd1, R_SEED = 3'd2, R_POLY = 3'd3,
    R_LEN  = 3'd4, R_DATA   = 3'd5, R_SIG  = 3'd6, R_CNT  = 3'd7
  } reg_idx_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic                 re;
    logic                 we;
    logic [NBIT_ADDR-1:0] addr;
    logic [NBIT_DATA-1:0] data;
  } req_t;

  req_t                 req;
  logic [NBIT_ADDR-1:0] off;
  logic                 mapped;
  reg_idx_t             idx;
  logic                 wr, rd;

  state_t               state;
  logic                 en, ovf;
  logic [NBIT_DATA-1:0] seed, poly, len, sig, cnt;
  logic [NBIT_DATA-1:0] sig_nxt, cnt_inc, rmux;
  logic                 busy, done;

  assign req    = '{re: re_misr_i, we: we_misr_i, addr: addr_misr_i, data: data_misr_i};
  assign off    = req.addr - BASE;
  assign mapped = (off < NBIT_ADDR'(32)) && (off[1:0] == 2'b00);
  assign idx    = reg_idx_t'(off[4:2]);
  // A write wins over a simultaneous read; the read is dropped entirely.
  assign wr     = req.we & mapped;
  assign rd     = req.re & ~req.we;

  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign irq_o = done;

  assign sig_nxt = {sig[NBIT_DATA-2:0], 1'b0} ^ (sig[NBIT_DATA-1] ? poly : '0) ^ req.data;
  assign cnt_inc = cnt + NBIT_DATA'(1);

  always_comb begin
    rmux = '0;
    case (idx)
      R_CTRL:   rmux = NBIT_DATA'(en);
      R_STATUS: rmux = NBIT_DATA'({ovf, done, busy});
      R_SEED:   rmux = seed;
      R_POLY:   rmux = poly;
      R_LEN:    rmux = len;
      R_SIG:    rmux = sig;
      R_CNT:    rmux = cnt;
      default:  rmux = '0;
    endcase
  end

  // Read path: data sampled before this cycle's register updates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= rd;
      err_o    <= (req.re | req.we) & ~mapped;
      if (rd) rdata_o <= mapped ? rmux : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      en    <= 1'b0;
      ovf   <= 1'b0;
      seed  <= '0;
      poly  <= POLY_RESET;
      len   <= '0;
      sig   <= '0;
      cnt   <= '0;
    end else if (wr) begin
      case (idx)
        R_CTRL: begin
          en <= req.data[0];
          if (req.data[1]) begin
            // Clear first, then EN is evaluated as if from IDLE.
            sig <= seed;
            cnt <= '0;
            ovf <= 1'b0;
            if (req.data[0]) state <= (len != '0) ? RUN : DONE;
            else             state <= IDLE;
          end else begin
            case (state)
              IDLE:    if (req.data[0]) state <= (len != '0) ? RUN : DONE;
              RUN:     if (!req.data[0]) state <= IDLE;
              default: state <= state;
            endcase
          end
        end
        R_SEED: seed <= req.data;
        R_POLY: poly <= req.data;
        R_LEN:  len  <= req.data;
        R_DATA: begin
          if (state == RUN) begin
            sig <= sig_nxt;
            cnt <= cnt_inc;
            if (cnt_inc == len) state <= DONE;
          end else if (state == DONE) begin
            ovf <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_misr_periph.sv
// Scoreboard bench for misr_periph: stimulus pushes expected read/err responses,
// a negedge monitor pops and compares whenever the DUT responds.
module tb_misr_periph;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00, A_STATUS = BASE + 32'h04,
                          A_SEED = BASE + 32'h08, A_POLY   = BASE + 32'h0C,
                          A_LEN  = BASE + 32'h10, A_DATA   = BASE + 32'h14,
                          A_SIG  = BASE + 32'h18, A_CNT    = BASE + 32'h1C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        re = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        rvalid, err, irq;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t rq[$];
  logic wq[$];
  int   tests = 0;
  int   fails = 0;

  misr_periph dut (
    .clk_i(clk), .rst_i(rst), .re_misr_i(re), .we_misr_i(we),
    .addr_misr_i(addr), .data_misr_i(wdata),
    .rdata_o(rdata), .rvalid_o(rvalid), .err_o(err), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rvalid) begin
      tests++;
      if (rq.size() == 0) begin
        fails++;
        $display("FAIL unexp_rvalid: got rvalid with data %h, none expected", rdata);
      end else begin
        rsp_t e;
        e = rq.pop_front();
        if (rdata !== e.data || err !== e.err) begin
          fails++;
          $display("FAIL read: got data %h err %b, want data %h err %b", rdata, err, e.data, e.err);
        end
      end
    end else if (err) begin
      tests++;
      if (wq.size() == 0) begin
        fails++;
        $display("FAIL unexp_err: got err_o=1 with no error expected");
      end else begin
        logic e;
        e = wq.pop_front();
        if (err !== e) begin
          fails++;
          $display("FAIL wr_err: got err %b, want %b", err, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    rq.push_back('{data: exp, err: 1'b0});
    re = 1'b1; addr = a;
    @(posedge clk); #1;
    re = 1'b0;
  endtask

  task automatic rd_bad(input logic [31:0] a);
    rq.push_back('{data: 32'h0, err: 1'b1});
    re = 1'b1; addr = a;
    @(posedge clk); #1;
    re = 1'b0;
  endtask

  task automatic wr_bad(input logic [31:0] a, input logic [31:0] d);
    wq.push_back(1'b1);
    wr(a, d);
  endtask

  initial begin
    // Reset, with a read issued during reset that must not respond.
    repeat (2) @(posedge clk);
    #1 re = 1'b1; addr = A_POLY;
    @(posedge clk); #1 re = 1'b0; rst = 1'b0;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_flags", {29'h0, rvalid, err, irq}, 32'h0);

    rd(A_SIG, 32'h0);
    rd(A_POLY, 32'h04C1_1DB7);
    rd(A_CTRL, 32'h0);
    rd(A_STATUS, 32'h0);
    rd(A_CNT, 32'h0);

    // Three-word run.
    wr(A_SEED, 32'h0);
    wr(A_CTRL, 32'h2);
    wr(A_LEN, 32'd3);
    wr(A_CTRL, 32'h1);
    rd(A_STATUS, 32'h1);
    wr(A_DATA, 32'h1);
    rd(A_SIG, 32'h1);
    wr(A_DATA, 32'h8000_0000);
    rd(A_SIG, 32'h8000_0002);
    chk("irq_run", {31'h0, irq}, 32'h0);
    wr(A_DATA, 32'h0);
    chk("irq_done", {31'h0, irq}, 32'h1);
    rd(A_SIG, 32'h04C1_1DB3);
    rd(A_CNT, 32'd3);
    rd(A_STATUS, 32'h2);
    rd(A_CTRL, 32'h1);
    rd(A_DATA, 32'h0);

    // Overflow in DONE, then clear.
    wr(A_DATA, 32'h5);
    rd(A_SIG, 32'h04C1_1DB3);
    rd(A_STATUS, 32'h6);
    rd(A_CNT, 32'd3);
    wr(A_SEED, 32'hDEAD_BEEF);
    wr(A_CTRL, 32'h2);
    chk("irq_clr", {31'h0, irq}, 32'h0);
    rd(A_STATUS, 32'h0);
    rd(A_SIG, 32'hDEAD_BEEF);
    rd(A_CNT, 32'h0);
    rd(A_CTRL, 32'h0);

    // Abort a LEN=4 run after two words.
    wr(A_LEN, 32'd4);
    wr(A_CTRL, 32'h1);
    wr(A_DATA, 32'h3);
    wr(A_DATA, 32'h7);
    wr(A_CTRL, 32'h0);
    rd(A_STATUS, 32'h0);
    rd(A_CNT, 32'd2);
    rd(A_SIG, 32'h77F5_DD64);
    wr(A_DATA, 32'h9);
    rd(A_CNT, 32'd2);
    rd(A_SIG, 32'h77F5_DD64);
    rd(A_STATUS, 32'h0);

    // LEN=0 goes straight to DONE.
    wr(A_CTRL, 32'h2);
    wr(A_LEN, 32'h0);
    wr(A_CTRL, 32'h1);
    chk("irq_len0", {31'h0, irq}, 32'h1);
    rd(A_STATUS, 32'h2);
    rd(A_CNT, 32'h0);

    // CLR and EN together from DONE: clear, then start.
    wr(A_LEN, 32'd2);
    wr(A_CTRL, 32'h3);
    chk("irq_clr_en", {31'h0, irq}, 32'h0);
    rd(A_STATUS, 32'h1);
    rd(A_SIG, 32'hDEAD_BEEF);
    rd(A_CNT, 32'h0);

    // Unmapped accesses and ignored RO write.
    rd_bad(BASE + 32'h20);
    wr_bad(BASE + 32'h2, 32'hFFFF_FFFF);
    rd_bad(BASE - 32'h4);
    rd_bad(BASE + 32'h1);
    rd(A_SEED, 32'hDEAD_BEEF);
    wr(A_STATUS, 32'hFF);
    rd(A_STATUS, 32'h1);
    wr(A_POLY, 32'h1);
    rd(A_POLY, 32'h1);

    // Simultaneous read and write: write lands, read dropped.
    re = 1'b1; we = 1'b1; addr = A_SEED; wdata = 32'h1234_5678;
    @(posedge clk); #1 re = 1'b0; we = 1'b0;
    rd(A_SEED, 32'h1234_5678);

    // Reset mid-run with a read in the same cycle.
    wr(A_DATA, 32'hA5A5_A5A5);
    rst = 1'b1; re = 1'b1; addr = A_SIG;
    @(posedge clk); #1 rst = 1'b0; re = 1'b0;
    chk("irq_midrst", {31'h0, irq}, 32'h0);
    rd(A_SEED, 32'h0);
    rd(A_POLY, 32'h04C1_1DB7);
    rd(A_STATUS, 32'h0);
    rd(A_SIG, 32'h0);
    rd(A_CNT, 32'h0);
    rd(A_LEN, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("pending", rq.size() + wq.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/misr_periph.md
Name: misr_periph

Overview:
- Memory-mapped MISR (multiple-input signature register) peripheral that consumes the MISR-side request outputs of the address decoder: re_misr/we_misr/addr_misr/data_misr.
- Holds a register file: control, status, seed, polynomial, length, data, signature and count. Compresses every word written to the DATA register into a 32-bit signature.
- A small FSM counts a programmed number of words and raises done and interrupt.
- Reads return one cycle after the request.

Parameters:
- NBIT_DATA, 32, data and signature width.
- NBIT_ADDR, 32, address width.
- MISR_PERIPH_START_ADDR, 2**25, base byte address of the register window; must be 32-byte aligned.
- POLY_RESET, 32'h04C1_1DB7, reset value of POLY.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- re_misr_i  input  1  read request (single-cycle)
- we_misr_i  input  1  write request (single-cycle)
- addr_misr_i  input  NBIT_ADDR  byte address
- data_misr_i  input  NBIT_DATA  write data
- rdata_o  output  NBIT_DATA  read data
- rvalid_o  output  1  read data valid, one-cycle pulse
- err_o  output  1  unmapped access, one-cycle pulse
- irq_o  output  1  level, equals STATUS.done

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Decode: off = addr_misr_i - MISR_PERIPH_START_ADDR. An access is mapped iff off < 32 and off[1:0] == 0. Register index is off[4:2].
- Register map:
  - 0x00 CTRL, RW: bit0 EN; bit1 CLR, write-only, reads 0.
  - 0x04 STATUS, RO: bit0 busy, bit1 done, bit2 ovf.
  - 0x08 SEED, RW.
  - 0x0C POLY, RW.
  - 0x10 LEN, RW.
  - 0x14 DATA, WO, reads 0.
  - 0x18 SIG, RO.
  - 0x1C CNT, RO.
- Writes to RO registers are silently ignored (no err).
- Reset values: SEED=0, POLY=POLY_RESET, LEN=0, SIG=0, CNT=0, EN=0, done=0, ovf=0, FSM=IDLE. Outputs: rdata_o=0, rvalid_o=0, err_o=0, irq_o=0.
- Reads:
  - A read at cycle t gives rdata_o and rvalid_o=1 at t+1.
  - rdata_o holds its value until the next read.
  - An unmapped read returns 0 with rvalid_o=1 and err_o=1 at t+1.
  - An unmapped write gives err_o=1 at t+1 and changes no state.
  - A read returns register contents before any same-cycle update.
- Simultaneous re_misr_i and we_misr_i: the write is performed and the read is dropped; no rvalid_o.
- Compression step: SIG_next = (SIG << 1) ^ (SIG[31] ? POLY : 0) ^ data. The shift is a NBIT_DATA-bit shift; the MSB is discarded.
- FSM states: IDLE, RUN, DONE. busy = (state == RUN); done = (state == DONE).
  - CLR=1 write, any state: SIG <= SEED, CNT <= 0, ovf <= 0, state <= IDLE, EN <= 0.
  - If the same CTRL write has both CLR=1 and EN=1: CLR applies first, then EN evaluates from IDLE in the same write (see next item).
  - IDLE, CTRL write with EN=1: LEN != 0 -> RUN; LEN == 0 -> DONE.
  - RUN, DATA write: compress, CNT <= CNT+1. If CNT+1 == LEN -> DONE.
  - RUN, CTRL write with EN=0, CLR=0 -> IDLE. SIG and CNT are kept.
  - DONE, DATA write: ignored, ovf <= 1 (sticky until CLR). Stays in DONE.
  - DONE, CTRL write with EN=1 and no CLR: stays in DONE.
  - IDLE, DATA write: ignored, no ovf.
- LEN, SEED and POLY writes during RUN take effect immediately. If the new LEN is <= CNT, the run completes only at CNT wrap (2^32 words); software must not do this.
- CNT is NBIT_DATA wide and wraps modulo 2^NBIT_DATA.
- Reset asserted mid-run returns every register to its reset value on the next edge. A read issued in the same cycle as reset produces no rvalid_o.

Test Plan:
- Reset, then read SIG (0x0200_0018) -> rvalid_o at t+1 with rdata_o=0. Read POLY -> 0x04C1_1DB7. err_o stays 0.
- SEED=0, CLR, LEN=3, CTRL=EN. Write DATA 0x1, 0x8000_0000, 0x0 -> SIG = 0x1, then 0x8000_0002, then 0x04C1_1DB3. CNT=3. STATUS=0b010. irq_o=1 after the third write.
- After the run above, write DATA 0x5 -> SIG unchanged, STATUS=0b110. Then CLR -> STATUS=0, irq_o=0, SIG=SEED.
- In RUN with LEN=4 after 2 words, write CTRL=0 -> IDLE, busy=0, CNT=2, SIG kept. A further DATA write leaves CNT=2.
- LEN=0, CTRL=EN -> DONE next cycle, CNT=0, irq_o=1.
- Read at 0x0200_0020 -> rdata_o=0, rvalid_o=1, err_o=1. Write at 0x0200_0002 -> err_o=1, no register change. re and we together on SEED -> SEED written, no rvalid_o.
